// File: rtl/stat_pkg.sv
// Purpose : shared constants for the statistics controller: opcode encodings,
//           counter index map, readout FSM encoding and the opcode classifier.
// Ports   : none (package).
// Config  : STAT_SAT_EN (consumed by stat_cnt) selects saturating counters.
package stat_pkg;

    // Opcodes that select a class counter
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;

    // Counter index map; also the order in which words are read out
    localparam int         NUM_CNT = 4;
    localparam logic [1:0] IDX_R   = 2'd0;
    localparam logic [1:0] IDX_I   = 2'd1;
    localparam logic [1:0] IDX_J   = 2'd2;
    localparam logic [1:0] IDX_CYC = 2'd3;

    // Readout FSM encoding
    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_SEND = 1'b1;

    // One-hot class of an opcode, bit positions match IDX_R/IDX_I/IDX_J.
    // Unknown opcodes return all zeros so they touch no counter.
    function automatic logic [2:0] op_class(input logic [5:0] opc);
        logic [2:0] c;
        c = 3'b000;
        case (opc)
            OP_RTYPE:                            c = 3'b001;
            OP_LW, OP_SW, OP_BNE, OP_BEQ, OP_ANDI,
            OP_ORI, OP_SLTI, OP_ADDI, OP_ADDIU:  c = 3'b010;
            OP_J, OP_JAL:                        c = 3'b100;
            default:                             c = 3'b000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/stat_cnt.sv
// Purpose : one statistics counter with enable and synchronous clear.
// Ports   : clk, rst (async active-low), en (count), clr (zero, wins over en), cnt.
// Config  : STAT_SAT_EN defined -> holds at all-ones; otherwise wraps to zero.
module stat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
`ifdef STAT_SAT_EN
            if (cnt != '1) begin
                cnt <= cnt + ONE;
            end
`else
            cnt <= cnt + ONE;
`endif
        end
    end

endmodule

// File: rtl/stat_ctrl.sv
// Purpose : retired-instruction statistics (R/I/J/cycle counters) with a
//           snapshot readout streamed one word per out_valid/out_ready handshake.
// Ports   : clk, rst (async active-low); op/op_valid retire stream; start/stop/
//           clear/dump_req command pulses; run, busy status; out_valid/out_ready/
//           out_idx/out_data readout stream.
// Config  : STAT_SAT_EN defined -> counters saturate instead of wrapping.
module stat_ctrl
    import stat_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic             op_valid,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             dump_req,
    output logic             run,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic [CNT_W-1:0] out_data
);

    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IDX_CYC);

    logic [2:0]         cls;
    logic [NUM_CNT-1:0] inc_en;
    logic [CNT_W-1:0]   cnt    [NUM_CNT];
    logic [CNT_W-1:0]   shadow [NUM_CNT];
    logic [0:0]         rd_state;

    // stop has priority so a simultaneous start/stop leaves counting off
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run <= 1'b0;
        end else if (stop) begin
            run <= 1'b0;
        end else if (start) begin
            run <= 1'b1;
        end
    end

    // Class bits are ordered like the counter indices, so they map straight
    // onto the enables; the cycle counter runs whenever run is set.
    assign cls    = op_class(op);
    assign inc_en = {run, {3{run & op_valid}} & cls};

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        stat_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .en  (inc_en[g]),
            .clr (clear),
            .cnt (cnt[g])
        );
    end

    // Readout. The snapshot samples the counters' current register values,
    // so a clear on the same edge is not visible in the dump.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_state <= RD_IDLE;
            out_idx  <= '0;
            for (int i = 0; i < NUM_CNT; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (dump_req) begin
                        for (int i = 0; i < NUM_CNT; i++) begin
                            shadow[i] <= cnt[i];
                        end
                        rd_state <= RD_SEND;
                        out_idx  <= '0;
                    end
                end
                RD_SEND: begin
                    if (out_ready) begin
                        if (out_idx == IDX_LAST) begin
                            rd_state <= RD_IDLE;
                            out_idx  <= '0;
                        end else begin
                            out_idx <= out_idx + IDX_ONE;
                        end
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    assign busy      = (rd_state == RD_SEND);
    assign out_valid = busy;
    // Data is forced to zero outside a readout so nothing stale leaks out
    assign out_data  = busy ? shadow[out_idx] : '0;

endmodule

// File: tb/tb_stat_ctrl.sv
module tb_stat_ctrl;

    localparam int CW   = 8;
    localparam int MAXV = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [5:0]    op = '0;
    logic          op_valid = 1'b0;
    logic          start = 1'b0, stop = 1'b0, clear = 1'b0, dump_req = 1'b0;
    logic          out_ready = 1'b0;
    logic          run, busy, out_valid;
    logic [1:0]    out_idx;
    logic [CW-1:0] out_data;

    stat_ctrl #(.CNT_W(CW), .IDX_W(2)) dut (
        .clk(clk), .rst(rst), .op(op), .op_valid(op_valid),
        .start(start), .stop(stop), .clear(clear), .dump_req(dump_req),
        .run(run), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_data(out_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int m_cnt [4];
    int m_sh  [4];
    bit m_run, m_busy;
    int m_idx;

    function automatic int cls_of(input logic [5:0] o);
        case (o)
            6'b000000:                                   return 0;
            6'b100011, 6'b101011, 6'b000101, 6'b000100,
            6'b001100, 6'b001101, 6'b001010, 6'b001000,
            6'b001001:                                   return 1;
            6'b000010, 6'b000011:                        return 2;
            default:                                     return -1;
        endcase
    endfunction

    function automatic int bump(input int v);
`ifdef STAT_SAT_EN
        return (v == MAXV) ? v : v + 1;
`else
        return (v + 1) % (MAXV + 1);
`endif
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                m_cnt[i] <= 0;
                m_sh[i]  <= 0;
            end
            m_run  <= 0;
            m_busy <= 0;
            m_idx  <= 0;
        end else begin
            if (!m_busy && dump_req) begin
                m_sh   <= m_cnt;
                m_busy <= 1;
                m_idx  <= 0;
            end else if (m_busy && out_ready) begin
                if (m_idx == 3) m_busy <= 0;
                m_idx <= (m_idx + 1) % 4;
            end
            if (clear) begin
                for (int i = 0; i < 4; i++) m_cnt[i] <= 0;
            end else if (m_run) begin
                m_cnt[3] <= bump(m_cnt[3]);
                if (op_valid && cls_of(op) >= 0)
                    m_cnt[cls_of(op)] <= bump(m_cnt[cls_of(op)]);
            end
            m_run <= stop ? 1'b0 : (start ? 1'b1 : m_run);
        end
    end

    // Per-cycle compare of all outputs against the model
    always @(negedge clk) begin
        if (rst) begin
            chk("run", run, m_run);
            chk("busy", busy, m_busy);
            chk("out_valid", out_valid, m_busy);
            if (m_busy) begin
                chk("out_idx", out_idx, m_idx);
                chk("out_data", out_data, m_sh[m_idx]);
            end
        end
    end

    // Words accepted by the sink, for literal checks of whole dumps
    int got [4];
    always @(posedge clk) begin
        if (rst && out_valid && out_ready) got[out_idx] = int'(out_data);
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic dump_all();
        int n;
        for (int i = 0; i < 4; i++) got[i] = -1;
        dump_req  = 1'b1;
        out_ready = 1'b1;
        cyc();
        dump_req = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            cyc();
            n++;
        end
        chk("dump_done", busy, 1'b0);
        out_ready = 1'b0;
    endtask

    task automatic run_ops(input logic [5:0] o, input int n);
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            op_valid = 1'b1;
            op       = o;
            stop     = (i == n - 1);
            cyc();
        end
        op_valid = 1'b0;
        stop     = 1'b0;
    endtask

    logic [5:0] pat [3];
    logic [5:0] rnd_ops [8];

    initial begin
        pat[0] = 6'b000000; pat[1] = 6'b100011; pat[2] = 6'b000010;
        rnd_ops[0] = 6'b000000; rnd_ops[1] = 6'b000011; rnd_ops[2] = 6'b000010;
        rnd_ops[3] = 6'b101011; rnd_ops[4] = 6'b001001; rnd_ops[5] = 6'b000100;
        rnd_ops[6] = 6'b111111; rnd_ops[7] = 6'b000001;

        // Reset state
        #12;
        chk("rst_run", run, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_idx", out_idx, 2'd0);
        chk("rst_data", out_data, 0);
        @(negedge clk);
        rst = 1'b1;
        cyc();

        // 12 ops in R, I, J rotation, stop with the last one
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            op_valid = 1'b1;
            op       = pat[i % 3];
            stop     = (i == 11);
            cyc();
        end
        op_valid = 1'b0;
        stop     = 1'b0;
        cyc();
        dump_all();
        chk("mix_R", got[0], 4);
        chk("mix_I", got[1], 4);
        chk("mix_J", got[2], 4);
        chk("mix_CYC", got[3], 12);

        // Backpressure: word 0 held for 5 cycles, then 4 back-to-back words
        dump_req = 1'b1;
        cyc();
        dump_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_idx", out_idx, 2'd0);
            chk("hold_data", out_data, 4);
            cyc();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("burst_idx", out_idx, k);
            cyc();
        end
        chk("burst_busy", busy, 1'b0);
        out_ready = 1'b0;

        // Not running: lw ops do not count
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        for (int i = 0; i < 10; i++) begin
            op_valid = 1'b1;
            op       = 6'b100011;
            cyc();
        end
        op_valid = 1'b0;
        dump_all();
        for (int i = 0; i < 4; i++) chk("idle_zero", got[i], 0);

        // dump_req together with clear at R=7; second dump_req while busy ignored
        run_ops(6'b000000, 7);
        for (int i = 0; i < 4; i++) got[i] = -1;
        dump_req = 1'b1;
        clear    = 1'b1;
        cyc();
        clear = 1'b0;
        cyc();
        chk("dup_busy", busy, 1'b1);
        dump_req = 1'b0;
        cyc();
        chk("dup_idx", out_idx, 2'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        out_ready = 1'b0;
        chk("dup_done", busy, 1'b0);
        chk("snap_R", got[0], 7);
        chk("snap_CYC", got[3], 7);
        dump_all();
        chk("live_R", got[0], 0);
        chk("live_CYC", got[3], 0);

        // Wrap / saturate boundary: all-ones then one more R op
        run_ops(6'b000000, MAXV + 1);
        dump_all();
`ifdef STAT_SAT_EN
        chk("edge_R", got[0], MAXV);
        chk("edge_CYC", got[3], MAXV);
`else
        chk("edge_R", got[0], 0);
        chk("edge_CYC", got[3], 0);
`endif

        // Randomised traffic against the model
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            op        = rnd_ops[$urandom_range(0, 7)];
            op_valid  = ($urandom_range(0, 1) == 1);
            start     = ($urandom_range(0, 19) == 0);
            stop      = ($urandom_range(0, 29) == 0);
            clear     = ($urandom_range(0, 49) == 0);
            dump_req  = ($urandom_range(0, 19) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            cyc();
        end
        op_valid = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; dump_req = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) cyc();
        chk("rand_idle", busy, 1'b0);
        out_ready = 1'b0;

        // Reset in the middle of a readout at idx 2
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        dump_req  = 1'b1;
        out_ready = 1'b1;
        cyc();
        dump_req = 1'b0;
        cyc();
        cyc();
        chk("mid_idx", out_idx, 2'd2);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_run", run, 1'b0);
        out_ready = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        chk("rel_valid", out_valid, 1'b0);
        chk("rel_busy", busy, 1'b0);
        chk("rel_run", run, 1'b0);
        chk("rel_idx", out_idx, 2'd0);
        chk("rel_data", out_data, 0);
        dump_all();
        for (int i = 0; i < 4; i++) chk("rel_cnt", got[i], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
